mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / memory-stage) arbiter in front of one shared memory port.
// Latency: grant registers the bus one edge after the request; done is the first ACC cycle with mem_ready.
// Backpressure: requesters are stalled until their done strobe; the bus holds stable until mem_ready.
module mem_arbiter (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        IReqF,
    input  logic [31:0] IAddrF,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [31:0] DAddrM,
    input  logic [31:0] WriteDataM,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [31:0] InstrF,
    output logic [31:0] ReadDataM,
    output logic        IDoneF,
    output logic        DDoneM,
    output logic        IStallF,
    output logic        DStallM,
    output logic        Timeout
);

    typedef enum logic [1:0] {IDLE, I_ACC, D_ACC} state_t;

    // last_grant encoding: remembers who won the previous grant for tie-breaking
    localparam logic GRANT_F = 1'b0;
    localparam logic GRANT_M = 1'b1;

    state_t     state;
    state_t     state_nxt;
    logic       last_grant;
    logic [7:0] wait_cnt;
    logic       grant_f;
    logic       grant_m;
    logic       in_acc;
    logic       acc_done;
    logic       acc_wait;

    assign in_acc   = (state != IDLE);
    assign acc_done = in_acc & mem_ready;
    assign acc_wait = in_acc & ~mem_ready;

    // Next-state and grant decision; ties go to whoever did not win last time
    always_comb begin
        state_nxt = state;
        grant_f   = 1'b0;
        grant_m   = 1'b0;
        case (state)
            IDLE: begin
                if (IReqF && (!MemReqM || last_grant == GRANT_M)) begin
                    grant_f   = 1'b1;
                    state_nxt = I_ACC;
                end else if (MemReqM) begin
                    grant_m   = 1'b1;
                    state_nxt = D_ACC;
                end
            end
            I_ACC, D_ACC: begin
                if (mem_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Bus registers: loaded on grant, held through the access, strobe dropped on done
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 32'd0;
            mem_wdata <= 32'd0;
        end else if (grant_f) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= IAddrF;
            mem_wdata <= 32'd0;
        end else if (grant_m) begin
            mem_req   <= 1'b1;
            mem_we    <= MemWriteM;
            mem_addr  <= DAddrM;
            mem_wdata <= WriteDataM;
        end else if (acc_done) begin
            mem_req   <= 1'b0;
        end
    end

    // Tie-break memory, only moves when someone is actually granted
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_grant <= GRANT_M;
        end else if (grant_f) begin
            last_grant <= GRANT_F;
        end else if (grant_m) begin
            last_grant <= GRANT_M;
        end
    end

    // Wait counter and sticky hang flag; Timeout rises with the edge that takes the count to 255
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wait_cnt <= 8'd0;
            Timeout  <= 1'b0;
        end else begin
            if (grant_f || grant_m) begin
                wait_cnt <= 8'd0;
            end else if (acc_wait && wait_cnt != 8'hFF) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (acc_wait && wait_cnt == 8'hFE) begin
                Timeout <= 1'b1;
            end
        end
    end

    // Done/stall strobes; a flushed fetch still finishes on the bus but reports no done
    always_comb begin
        DDoneM    = (state == D_ACC) & mem_ready;
        IDoneF    = (state == I_ACC) & mem_ready & IReqF;
        DStallM   = MemReqM & ~DDoneM;
        IStallF   = IReqF & ~IDoneF;
        ReadDataM = DDoneM ? mem_rdata : 32'd0;
        InstrF    = IDoneF ? mem_rdata : 32'd0;
    end

endmodule
